// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared parameters, FSM state type and index helper for the register file
package regfile_pkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;
   localparam int IDX_MAXW = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

   function automatic logic is_x0(input logic [IDX_MAXW-1:0] idx);
      return (idx == '0);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with issue-over-writeback priority
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREG = NREG_DEF,
   localparam int IDXW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [IDXW-1:0] set_idx,
   input  logic            clr_en,
   input  logic [IDXW-1:0] clr_idx,
   input  logic [IDXW-1:0] ra,
   input  logic [IDXW-1:0] rb,
   output logic            busy_a,
   output logic            busy_b
);

   logic [NREG-1:0] pending;

   // set is applied after clear so a same-cycle issue leaves the register pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         if (clr_en && !is_x0(IDX_MAXW'(clr_idx)))
            pending[clr_idx] <= 1'b0;
         if (set_en && !is_x0(IDX_MAXW'(set_idx)))
            pending[set_idx] <= 1'b1;
      end
   end

   assign busy_a = pending[ra];
   assign busy_b = pending[rb];

endmodule

// File: rtl/banco_registradores_sb.sv
// rtl/banco_registradores_sb.sv - register file with post-reset clear sweep and scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass
module banco_registradores_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   parameter  int NREG = NREG_DEF,
   localparam int IDXW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IDXW-1:0] ra,
   input  logic [IDXW-1:0] rb,
   output logic [XLEN-1:0] douta,
   output logic [XLEN-1:0] doutb,
   output logic            busy_a,
   output logic            busy_b,
   input  logic            we,
   input  logic [IDXW-1:0] rw,
   input  logic [XLEN-1:0] din,
   input  logic            iss_valid,
   input  logic [IDXW-1:0] iss_rd,
   output logic            ready
);

   rf_state_e       state, state_nx;
   logic [IDXW-1:0] sweep_idx;
   logic            sweep_en;
   logic [XLEN-1:0] regs [NREG];
   logic            wr_run;
   logic            pend_a, pend_b;
   logic            byp_a, byp_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == CLEAR && sweep_idx == IDXW'(NREG-1))
         state_nx = RUN;
   end

   always_comb begin
      ready    = (state == RUN);
      sweep_en = (state == CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        sweep_idx <= IDXW'(1);
      else if (sweep_en) sweep_idx <= sweep_idx + 1'b1;
   end

   assign wr_run = ready && we && !is_x0(IDX_MAXW'(rw));

   // storage is deliberately unreset; the sweep zeroes it once rst_n is released
   always_ff @(posedge clk) begin
      if (sweep_en)    regs[sweep_idx] <= '0;
      else if (wr_run) regs[rw] <= din;
   end

   regfile_scoreboard #(.NREG(NREG)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (ready && iss_valid),
      .set_idx (iss_rd),
      .clr_en  (wr_run),
      .clr_idx (rw),
      .ra      (ra),
      .rb      (rb),
      .busy_a  (pend_a),
      .busy_b  (pend_b)
   );

`ifdef REGFILE_BYPASS_EN
   assign byp_a = wr_run && (rw == ra);
   assign byp_b = wr_run && (rw == rb);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_comb begin
      douta  = '0;
      doutb  = '0;
      busy_a = 1'b0;
      busy_b = 1'b0;
      if (ready) begin
         if (byp_a)                          douta = din;
         else if (!is_x0(IDX_MAXW'(ra)))     douta = regs[ra];
         if (byp_b)                          doutb = din;
         else if (!is_x0(IDX_MAXW'(rb)))     doutb = regs[rb];
         busy_a = pend_a && !byp_a;
         busy_b = pend_b && !byp_b;
      end
   end

endmodule
